// File: rtl/pipelined_block_cla.sv
// rtl/pipelined_block_cla.sv - multi-cycle adder/subtractor resolving one carry-lookahead block per clock
//
// Purpose: adds or subtracts two WIDTH-bit operands, BLK bits per RUN cycle,
// using a flattened lookahead carry network inside each block and a registered
// carry between blocks. One operation takes NB = WIDTH/BLK RUN cycles plus one
// DONE cycle.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   start    - request an operation (only looked at in IDLE)
//   sub      - 0 = a + b + cin, 1 = a - b
//   a, b     - operands, captured with start
//   cin      - carry-in for add, ignored for subtract
//   sum      - registered result, valid from done until the next accepted start
//   cout     - registered carry out of the MSB (subtract: 1 = no borrow)
//   overflow - registered signed overflow
//   busy     - high while resolving blocks
//   done     - one-cycle pulse when the result is complete
module pipelined_block_cla #(
  parameter int WIDTH = 8,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NB   = WIDTH / BLK;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [IDXW-1:0]  idx_q;

  // Current block slice and its lookahead network.
  logic [BLK-1:0] blk_a;
  logic [BLK-1:0] blk_b;
  logic [BLK-1:0] blk_g;
  logic [BLK-1:0] blk_p;
  logic [BLK:0]   blk_c;
  logic [BLK-1:0] blk_sum_d;
  logic           carry_d;
  logic           term_or;
  logic           prop_and;

  always_comb begin
    blk_a     = op_a_q[idx_q*BLK +: BLK];
    blk_b     = op_b_q[idx_q*BLK +: BLK];
    blk_g     = blk_a & blk_b;
    blk_p     = blk_a ^ blk_b;
    blk_c     = '0;
    blk_c[0]  = carry_q;
    term_or   = 1'b0;
    prop_and  = 1'b0;
    // Each carry is built directly as a sum of products of g, p and the block
    // carry-in (g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin), so no
    // carry depends on a lower carry inside the block.
    for (int i = 0; i < BLK; i++) begin
      term_or  = blk_g[i];
      prop_and = blk_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_or  = term_or | (prop_and & blk_g[j]);
        prop_and = prop_and & blk_p[j];
      end
      blk_c[i+1] = term_or | (prop_and & carry_q);
    end
    blk_sum_d = blk_p ^ blk_c[BLK-1:0];
    carry_d   = blk_c[BLK];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q  <= a;
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*BLK +: BLK] <= blk_sum_d;
          carry_q                 <= carry_d;
          idx_q                   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
            // Carry into the MSB is the block's internal carry at its top bit.
            ovf_q   <= carry_d ^ blk_c[BLK-1];
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_pipelined_block_cla.sv
// tb/tb_pipelined_block_cla.sv - self-checking bench for pipelined_block_cla
module tb_pipelined_block_cla;

  localparam int W  = 8;
  localparam int BK = 4;
  localparam int NB = W / BK;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pipelined_block_cla #(.WIDTH(W), .BLK(BK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Plain arithmetic reference: returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rc, input logic rs);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rs ? 1'b1 : rc)};
    ov   = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return {ov, full};
  endfunction

  // Timing model: m_cnt = 0 idle, 1..NB resolving, NB+1 done cycle.
  int           m_cnt   = 0;
  bit           m_valid = 0;
  logic [W+1:0] m_pend  = '0;
  logic [W+1:0] m_vis   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_vis   = '0;
      m_valid = 1;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend = ref_op(a, b, cin, sub);
        m_cnt  = 1;
      end
    end else if (m_cnt == NB) begin
      m_vis = m_pend;
      m_cnt = NB + 1;
    end else if (m_cnt == NB + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model busy", {31'd0, busy}, {31'd0, (m_cnt >= 1 && m_cnt <= NB)});
      chk("model done", {31'd0, done}, {31'd0, (m_cnt == NB + 1)});
      if (!(m_cnt >= 1 && m_cnt <= NB))
        chk("model result", {22'd0, overflow, cout, sum}, {22'd0, m_vis});
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input logic eo, input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, " latency"}, n, NB);
    chk({nm, " sum"}, {24'd0, sum}, {24'd0, es});
    chk({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
    chk({nm, " ovf"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  logic [W-1:0] cont_a  [3] = '{8'h11, 8'hF0, 8'h40};
  logic [W-1:0] cont_b  [3] = '{8'h22, 8'h20, 8'h40};
  logic [W-1:0] cont_s  [3] = '{8'h33, 8'h10, 8'h80};
  logic         cont_c  [3] = '{1'b0, 1'b1, 1'b0};
  logic         cont_o  [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int dones;
    int k;
    int t;
    int done_cyc [3];
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    repeat (2) @(negedge clk);
    chk("reset sum", {24'd0, sum}, 32'd0);
    chk("reset flags", {28'd0, cout, overflow, busy, done}, 32'd0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add0f01");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "addff01");
    run_op(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "addaa55c");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "addffffc");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add7f01ovf");
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub0507");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub8001");

    // Held results survive idle cycles.
    repeat (3) @(negedge clk);
    chk("hold sum", {24'd0, sum}, 32'h7F);

    // Start while busy is ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ignore busy", {31'd0, busy}, 32'd1);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("ignore dones", dones, 1);
    chk("ignore sum", {24'd0, sum}, 32'h02);

    // Reset on the first RUN edge abandons the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst sum", {24'd0, sum}, 32'd0);
    chk("midrst flags", {29'd0, cout, busy, done}, 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst nodone", dones, 0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "after rst");

    // Reset has priority over start on the same edge.
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst prio busy", {31'd0, busy}, 32'd0);

    // Continuous start: three operations back to back.
    @(negedge clk);
    a = cont_a[0]; b = cont_b[0]; cin = 1'b0; sub = 1'b0; start = 1'b1;
    k = 0; t = 0;
    while (k < 3 && t < 40) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (done) begin
        done_cyc[k] = cyc;
        chk("cont sum", {24'd0, sum}, {24'd0, cont_s[k]});
        chk("cont cout", {31'd0, cout}, {31'd0, cont_c[k]});
        chk("cont ovf", {31'd0, overflow}, {31'd0, cont_o[k]});
        k++;
        if (k < 3) begin
          a = cont_a[k]; b = cont_b[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("cont count", k, 3);
    if (k == 3) begin
      chk("cont gap1", done_cyc[1] - done_cyc[0], NB + 2);
      chk("cont gap2", done_cyc[2] - done_cyc[1], NB + 2);
    end

    // Pseudo-random operations checked against the reference function.
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      r  = ref_op(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[W-1:0], r[W], r[W+1], "rand");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_block_cla.md
PIPELINED_BLOCK_CLA -- requirements
Module: pipelined_block_cla

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a positive multiple of BLK.
REQ-002 Parameter BLK, default 4, bits resolved per cycle by one carry-lookahead block; NB = WIDTH/BLK.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 Port a  input  WIDTH  operand A; sampled with start.
REQ-008 Port b  input  WIDTH  operand B; sampled with start.
REQ-009 Port cin  input  1  carry-in for add; ignored when sub=1.
REQ-010 Port sum  output  WIDTH  registered result.
REQ-011 Port cout  output  1  registered carry out of MSB (subtract: 1 = no borrow).
REQ-012 Port overflow  output  1  registered signed overflow flag.
REQ-013 Port busy  output  1  high while state = RUN.
REQ-014 Port done  output  1  single-cycle pulse, high while state = DONE.

Function
REQ-015 FSM states IDLE, RUN and DONE SHALL be the only states; encoding free.
REQ-016 In IDLE with start=1, the edge SHALL:
- latch a into op_a;
- latch b into op_b, or ~b when sub=1;
- set carry register = (sub ? 1 : cin);
- set block index = 0;
- enter RUN.
REQ-017 In IDLE with start=0, state and all outputs SHALL hold.
REQ-018 Each RUN edge SHALL resolve block k = index.
- Block k covers bits [k*BLK +: BLK], using generate g=a&b, propagate p=a^b and lookahead carries c[i+1] = g[i] | p[i]&c[i], flattened (not rippled) within the block.
- Results go to sum[k*BLK +: BLK].
- The carry register SHALL be updated to the block carry-out.
- index SHALL increment.
REQ-019 On the RUN edge where index = NB-1, the edge SHALL also:
- set cout = final carry-out;
- set overflow = carry into MSB XOR carry out of MSB;
- enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle following the NB-th rising edge after the edge that sampled start. With NB=2, done rises on the 2nd edge after the start edge.
REQ-022 start asserted in RUN or DONE SHALL be ignored; no queuing. Operands and sub changing during RUN SHALL NOT affect the result.
REQ-023 sum, cout and overflow SHALL hold their last values from DONE through IDLE until the next accepted start. During RUN, partially updated sum bits are permitted and are not valid until done.
REQ-024 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after DONE, giving one operation per NB+2 cycles.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; results SHALL equal {cout,sum} = a + b + cin (add) or a + ~b + 1 (sub).

Reset
REQ-026 rst=1 at a rising edge SHALL force, regardless of state (including mid-RUN):
- state = IDLE, index = 0, carry register = 0;
- sum = 0, cout = 0, overflow = 0, busy = 0, done = 0.
The operation in progress SHALL be abandoned with no done pulse.
REQ-027 rst SHALL take priority over start on the same edge.

Verification (WIDTH=8, BLK=4)
REQ-028 The bench SHALL cover these add cases; each SHALL produce done 2 edges after start.
- a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, overflow=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
- a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, overflow=0.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0.
REQ-029 Signed overflow case: add a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
REQ-030 Subtract cases:
- a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, overflow=0 (cin ignored).
- a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
REQ-031 Busy-ignore case: pulse start with 0x01+0x01, then assert start with 0x10+0x10 while busy=1 -> exactly one done, sum=0x02; the second request is not executed.
REQ-032 Mid-operation reset: start 0xFF+0x01, assert rst on the first RUN edge -> no done pulse; sum=0x00, cout=0, busy=0 the cycle after; the next start operates normally.
REQ-033 Continuous start: hold start=1 for 3 operations -> done pulses spaced exactly 4 cycles apart, each result correct.
